// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the SPI ADC link: default widths, the frame
// state encoding, and the frame-length helper used by both link ends.
package adc_spi_pkg;

  localparam int DATA_W_DEF     = 12;
  localparam int LEAD_ZEROS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_t;

  // Bits per frame: leading zeros followed by the sample.
  function automatic int frame_len(input int data_w, input int lead_zeros);
    return data_w + lead_zeros;
  endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// Three-wire SPI link between an ADC-style master and this responder.
interface adc_spi_responder_if;

  logic sclk;  // idles high
  logic ss;    // active-low frame select
  logic miso;

  modport master (output sclk, output ss, input miso);
  modport slave  (input sclk, input ss, output miso);

endinterface

// File: rtl/spi_edge_sync.sv
// Brings an asynchronous SPI pin into the clk domain and flags its
// rising and falling edges as single-cycle pulses.
// SYNC_STAGES must be at least 2.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain plus one extra copy for edge detection; all flops
  // reset to 1, the idle level of both sclk and ss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge pulses from the last synchronized stage and its delayed copy.
  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating an AD7476-style ADC: each ss-framed transfer shifts
// out LEAD_ZEROS zeros followed by the held sample, MSB first, advancing
// on synchronized sclk falling edges.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  adc_spi_responder_if.slave  spi,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_abort,
  output logic                overrun
);

  localparam int FRAME_LEN = frame_len(DATA_W, LEAD_ZEROS);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  spi_state_t             state_q, state_d;
  logic [FRAME_LEN-1:0]   shift_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      hold_q;
  logic                   hold_full_q;

  logic unused_sclk_rise;  // the master samples on rising sclk; nothing to do here
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;
  logic load;
  logic shift_en;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi.sclk),
    .rise (unused_sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi.ss),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // Frame start and bit-advance qualifiers; an ss rise beats a same-cycle sclk edge.
  always_comb begin
    load     = (state_q == IDLE) && ss_fall;
    shift_en = (state_q == SHIFT) && sclk_fall && !ss_rise;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps unlisted paths
    // from holding their value, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_fall) state_d = SHIFT;
      SHIFT: begin
        if (ss_rise)                             state_d = IDLE;
        else if (sclk_fall && cnt_q == LAST_BIT) state_d = DONE;
      end
      DONE:    if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: miso is only live in SHIFT; pulses come from the edge that ends the frame.
  always_comb begin
    spi.miso    = (state_q == SHIFT) ? shift_q[FRAME_LEN-1] : 1'b0;
    busy        = (state_q != IDLE);
    frame_done  = (state_q == DONE) && ss_rise;
    frame_abort = (state_q == SHIFT) && ss_rise;
    overrun     = sample_valid && hold_full_q && !load;
  end

  // Shift register, bit counter and sample holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath is reset too, so a frame taken straight after
      // reset shifts out a defined all-zero word rather than X.
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (load) begin
        shift_q <= {{LEAD_ZEROS{1'b0}}, hold_q};
        cnt_q   <= '0;
      end else if (shift_en) begin
        shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
        cnt_q   <= cnt_q + CNT_W'(1);
      end

      // A load reads the old sample; a same-cycle write still lands and wins.
      if (sample_valid) hold_q <= sample_in;

      if (sample_valid) hold_full_q <= 1'b1;
      else if (load)    hold_full_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a behavioural SPI master at clk/8
// runs table-driven frames, then hand-written same-cycle and reset cases.
module tb_adc_spi_responder;

  localparam int HALF = 4;  // clk cycles per sclk half period

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        busy, frame_done, frame_abort, overrun;

  adc_spi_responder_if spi ();

  adc_spi_responder dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi.slave),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_abort  = 0;
  int n_ovr    = 0;

  // Pulse monitor, sampling mid-cycle after inputs driven on negedge settle.
  always begin
    @(negedge clk);
    #1;
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
    if (overrun)     n_ovr++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [11:0] v);
    @(negedge clk);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Master: ss low, then nfalls sclk cycles; each bit is sampled at the end
  // of the sclk-high half period that precedes a falling edge.
  task automatic run_frame(input int nfalls, input bit strobe_at_load, input logic [11:0] sv,
                           output logic [15:0] word, output logic busy_mid,
                           output logic miso_end, output logic busy_end);
    word = '0;
    @(negedge clk);
    spi.ss = 1'b0;
    if (strobe_at_load) begin
      tick(2);  // the load happens on the next posedge
      sample_in    = sv;
      sample_valid = 1'b1;
      tick(1);
      sample_valid = 1'b0;
      tick(HALF - 3);
    end else begin
      tick(HALF);
    end
    busy_mid = busy;
    for (int k = 0; k < nfalls; k++) begin
      word = {word[14:0], spi.miso};
      spi.sclk = 1'b0;
      tick(HALF);
      spi.sclk = 1'b1;
      tick(HALF);
    end
    miso_end = spi.miso;
    busy_end = busy;
    spi.ss = 1'b1;
    tick(HALF + 2);
  endtask

  typedef struct {
    bit          use_s0;
    logic [11:0] s0;
    bit          use_s1;
    logic [11:0] s1;
    int          nfalls;
    logic [15:0] exp_word;
    int          exp_done;
    int          exp_abort;
    int          exp_ovr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [15:0] word;
    logic        busy_mid, miso_end, busy_end;
    int          d0, a0, o0;

    vecs[0] = '{1'b1, 12'hA5C, 1'b0, 12'h000, 16, 16'h0A5C, 1, 0, 0};
    vecs[1] = '{1'b1, 12'h000, 1'b0, 12'h000, 16, 16'h0000, 1, 0, 0};
    vecs[2] = '{1'b1, 12'hFFF, 1'b0, 12'h000,  7, 16'h0000, 0, 1, 0};
    vecs[3] = '{1'b0, 12'h000, 1'b0, 12'h000, 16, 16'h0FFF, 1, 0, 0};
    vecs[4] = '{1'b1, 12'h123, 1'b1, 12'h456, 16, 16'h0456, 1, 0, 1};
    vecs[5] = '{1'b1, 12'h801, 1'b0, 12'h000, 16, 16'h0801, 1, 0, 0};

    spi.sclk = 1'b1;
    spi.ss   = 1'b1;

    // Reset, then idle with no link activity.
    tick(5);
    check("reset_miso", {31'd0, spi.miso}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick(10);
    check("idle_miso", {31'd0, spi.miso}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_pulses", n_done + n_abort + n_ovr, 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      d0 = n_done; a0 = n_abort; o0 = n_ovr;
      if (vecs[i].use_s0) strobe(vecs[i].s0);
      if (vecs[i].use_s1) strobe(vecs[i].s1);
      run_frame(vecs[i].nfalls, 1'b0, 12'h000, word, busy_mid, miso_end, busy_end);
      if (vecs[i].nfalls == 16) begin
        check($sformatf("v%0d_word", i), {16'd0, word}, {16'd0, vecs[i].exp_word});
        check($sformatf("v%0d_miso_done", i), {31'd0, miso_end}, 32'd0);
        check($sformatf("v%0d_busy_done", i), {31'd0, busy_end}, 32'd1);
      end
      check($sformatf("v%0d_busy_mid", i), {31'd0, busy_mid}, 32'd1);
      check($sformatf("v%0d_done", i), n_done - d0, vecs[i].exp_done);
      check($sformatf("v%0d_abort", i), n_abort - a0, vecs[i].exp_abort);
      check($sformatf("v%0d_overrun", i), n_ovr - o0, vecs[i].exp_ovr);
      check($sformatf("v%0d_miso_idle", i), {31'd0, spi.miso}, 32'd0);
      check($sformatf("v%0d_busy_idle", i), {31'd0, busy}, 32'd0);
    end

    // Strobe in the load cycle: the load sends the old sample, no overrun,
    // and the new sample stays held for the following frame.
    strobe(12'h111);
    o0 = n_ovr; d0 = n_done;
    run_frame(16, 1'b1, 12'h222, word, busy_mid, miso_end, busy_end);
    check("same_cycle_word", {16'd0, word}, 32'h0111);
    check("same_cycle_overrun", n_ovr - o0, 32'd0);
    run_frame(16, 1'b0, 12'h000, word, busy_mid, miso_end, busy_end);
    check("same_cycle_next_word", {16'd0, word}, 32'h0222);
    check("same_cycle_done", n_done - d0, 32'd2);

    // Reset after 9 sclk cycles of a frame.
    strobe(12'h5A5);
    d0 = n_done; a0 = n_abort;
    @(negedge clk);
    spi.ss = 1'b0;
    tick(HALF);
    for (int k = 0; k < 9; k++) begin
      spi.sclk = 1'b0;
      tick(HALF);
      spi.sclk = 1'b1;
      tick(HALF);
    end
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_miso", {31'd0, spi.miso}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    spi.ss = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(5);
    check("midrst_no_pulse", (n_done - d0) + (n_abort - a0), 32'd0);
    d0 = n_done;
    strobe(12'h789);
    run_frame(16, 1'b0, 12'h000, word, busy_mid, miso_end, busy_end);
    check("post_rst_word", {16'd0, word}, 32'h0789);
    check("post_rst_done", n_done - d0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI slave that emulates the 12-bit ADC front end (AD7476-style frame: 4 leading zeros, then 12 data bits MSB first) on the miso/sclk/ss link.
- Serves as the far end of the system's SPI ADC receiver, for loopback bring-up and for self-checking benches.
- Sample words come from a parallel source, e.g. a test pattern or a filter output, and are shifted out once per ss-framed transfer.

Parameters:
- DATA_W, 12: sample width in bits.
- LEAD_ZEROS, 4: zero bits sent before the sample MSB.
- FRAME_LEN, DATA_W+LEAD_ZEROS (16): bits per frame; local, not overridable.
- SYNC_STAGES, 2: synchronizer depth for sclk and ss.

Ports:
- clk  in  1  system clock; must run at least 4x sclk.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master; idles high; asynchronous to clk.
- ss  in  1  active-low frame select from master; asynchronous to clk.
- miso  out  1  serial data to master.
- sample_in  in  DATA_W  parallel sample to transmit.
- sample_valid  in  1  one-cycle strobe; writes sample_in into the holding register.
- busy  out  1  high while a frame is in progress (states SHIFT and DONE).
- frame_done  out  1  one-cycle pulse when ss deasserts after a complete FRAME_LEN-bit frame.
- frame_abort  out  1  one-cycle pulse when ss deasserts before the frame is complete.
- overrun  out  1  one-cycle pulse when sample_valid overwrites a held sample that was never sent.

Behaviour:
- Reset (rst low, asynchronous):
  - miso=0, busy=0, frame_done=0, frame_abort=0, overrun=0.
  - Holding register = 0, hold_full=0, bit counter = 0, state = IDLE.
  - Synchronizer flops reset to 1, which is the idle level of sclk and ss.
- Synchronization: sclk and ss each pass through SYNC_STAGES flops. Edge detection compares the last synchronized stage with one further registered copy.
- Holding register:
  - sample_valid writes sample_in and sets hold_full.
  - If hold_full is already 1, overrun pulses in the same cycle.
- State IDLE:
  - miso=0.
  - On a synchronized ss falling edge: load shift register = {LEAD_ZEROS zeros, holding register}, clear hold_full, bit counter = 0, go to SHIFT.
  - If hold_full=0 at load time, the previous sample is resent; this is not an error.
  - miso presents shift register bit FRAME_LEN-1 (a zero) from the cycle after the load.
- State SHIFT:
  - On each synchronized sclk falling edge: shift left by one, increment the bit counter, miso = new MSB.
  - The master samples on sclk rising edges, so bit k is valid for a full sclk-high half period.
  - The first bit is driven on the ss falling edge, not on an sclk edge. The 15 following sclk falling edges advance through bits 14..0.
  - The 16th sclk falling edge (bit counter reaches FRAME_LEN) goes to DONE with miso=0.
- State DONE:
  - miso=0; any further sclk edges are ignored.
  - On a synchronized ss rising edge: pulse frame_done, go to IDLE.
- Early ss rise in SHIFT: pulse frame_abort, go to IDLE, miso=0, no frame_done. The holding register is not restored; the sample counts as consumed.
- Simultaneous events:
  - sample_valid in the same cycle as the load: the load uses the old holding contents. The new sample is written and hold_full ends at 1 (set wins over clear). No overrun is flagged for that cycle.
  - sclk edge in the same cycle as the ss rising edge: the ss rising edge wins.
- Latency: miso updates 1+SYNC_STAGES clk cycles after the pin edge, 3 cycles at default. This is why clk must be at least 4x sclk.
- ss falling edges outside IDLE are ignored. A new frame needs ss to return high first.
- Reset mid-frame: immediate return to IDLE with miso=0. The frame in flight is lost and no pulse is generated.

Decomposition:
- Shared package adc_spi_pkg holds:
  - DATA_W_DEF=12, LEAD_ZEROS_DEF=4.
  - A state enum {IDLE, SHIFT, DONE}.
  - The frame-length function used by both the receiver and this responder.
- One sub-module, spi_edge_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs. Instantiate it once for sclk and once for ss.

Test Plan:
- Reset then idle: hold rst low for 5 cycles, release; no ss activity -> miso=0, busy=0, all pulses 0.
- Nominal frame: sample_valid with 12'hA5C; ss low; 16 sclk cycles at clk/8 -> master captures 16'h0A5C, frame_done pulses once after ss high, busy low afterwards.
- Loopback: connect to the system's SPI ADC receiver with ramp samples 0x000..0x00F, one per frame -> receiver data_out equals each ramp value in order with data_valid per frame; frame_abort and overrun never pulse.
- Early abort: sample 12'hFFF, ss rises after 7 sclk cycles -> frame_abort pulses once, no frame_done, miso=0. The next full frame resends 12'hFFF, giving 16'h0FFF.
- Overrun: two sample_valid strobes (12'h123, then 12'h456) with no frame between -> overrun pulses on the second strobe; the next frame carries 16'h0456.
- Mid-frame reset: assert rst after 9 sclk cycles -> miso=0 and state IDLE immediately. After release, a full frame with 12'h789 yields 16'h0789 with frame_done.
